// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared constants, state encoding and BCD-to-binary helper
//               for the seven-segment scan decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Active-low segment patterns, bit6..bit0 = a..g
    localparam logic [6:0] c_SEG_0 = 7'b0000001;
    localparam logic [6:0] c_SEG_1 = 7'b1001111;
    localparam logic [6:0] c_SEG_2 = 7'b0010010;
    localparam logic [6:0] c_SEG_3 = 7'b0000110;
    localparam logic [6:0] c_SEG_4 = 7'b1001100;
    localparam logic [6:0] c_SEG_5 = 7'b0100100;
    localparam logic [6:0] c_SEG_6 = 7'b0100000;
    localparam logic [6:0] c_SEG_7 = 7'b0001111;
    localparam logic [6:0] c_SEG_8 = 7'b0000000;
    localparam logic [6:0] c_SEG_9 = 7'b0000100;

    // Active-low one-hot digit selects
    localparam logic [3:0] c_AN_POS3  = 4'b0111;
    localparam logic [3:0] c_AN_POS2  = 4'b1011;
    localparam logic [3:0] c_AN_POS1  = 4'b1101;
    localparam logic [3:0] c_AN_POS0  = 4'b1110;
    localparam logic [3:0] c_AN_BLANK = 4'b1111;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_EXP2 = 3'd1,
        ST_EXP1 = 3'd2,
        ST_EXP0 = 3'd3,
        ST_EXP3 = 3'd4
    } ssd_state_t;

    // d3*1000 + d2*100 + d1*10 + d0 using shifts and adds only
    function automatic logic [15:0] bcd_to_bin(
        input logic [3:0] d3,
        input logic [3:0] d2,
        input logic [3:0] d1,
        input logic [3:0] d0
    );
        logic [15:0] e3;
        logic [15:0] e2;
        logic [15:0] e1;
        logic [15:0] e0;
        e3 = {12'd0, d3};
        e2 = {12'd0, d2};
        e1 = {12'd0, d1};
        e0 = {12'd0, d0};
        return (e3 << 10) - (e3 << 4) - (e3 << 3)
             + (e2 << 6) + (e2 << 5) + (e2 << 2)
             + (e1 << 3) + (e1 << 1)
             + e0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : ssd_seg_decode
// Description : Combinational active-low seven-segment pattern to digit
//               decoder with a valid flag for unrecognised patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            c_SEG_0: digit = 4'd0;
            c_SEG_1: digit = 4'd1;
            c_SEG_2: digit = 4'd2;
            c_SEG_3: digit = 4'd3;
            c_SEG_4: digit = 4'd4;
            c_SEG_5: digit = 4'd5;
            c_SEG_6: digit = 4'd6;
            c_SEG_7: digit = 4'd7;
            c_SEG_8: digit = 4'd8;
            c_SEG_9: digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_decoder
// Description : Receives a multiplexed four-digit seven-segment scan and
//               reconstructs the displayed decimal number per full frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_decoder
    import ssd_pkg::*;
#(
    parameter int DWELL_MIN   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] value,
    output logic [15:0] digits_bcd,
    output logic        value_valid,
    output logic        frame_error,
    output logic        locked
);

    localparam int c_SMP_W = 11;
    localparam int c_CNT_W = (DWELL_MIN > 2) ? $clog2(DWELL_MIN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_PRE = c_CNT_W'(DWELL_MIN - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(DWELL_MIN - 1);

    // Synchronizer: shift register of {anode, seg} samples, blank on reset
    logic [SYNC_STAGES*c_SMP_W-1:0] r_sync;
    logic [c_SMP_W-1:0]             w_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[(SYNC_STAGES-1)*c_SMP_W-1:0], anode_in, seg_in};
        end
    end

    assign w_sample = r_sync[SYNC_STAGES*c_SMP_W-1 -: c_SMP_W];

    // Dwell filter
    logic [c_SMP_W-1:0] r_prev;
    logic [c_CNT_W-1:0] r_dwell;
    logic               w_same;
    logic               w_accept;

    assign w_same   = (w_sample == r_prev);
    // Fires on the edge that takes the counter to saturation, so only once
    assign w_accept = w_same && (r_dwell == c_CNT_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '1;
            r_dwell <= '0;
        end else begin
            r_prev <= w_sample;
            if (!w_same) begin
                r_dwell <= '0;
            end else if (r_dwell != c_CNT_SAT) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Sample classification
    logic [3:0] w_anode;
    logic [6:0] w_seg;
    logic [3:0] w_digit;
    logic       w_code_ok;
    logic       w_blank;

    assign w_anode = w_sample[10:7];
    assign w_seg   = w_sample[6:0];
    assign w_blank = (w_anode == c_AN_BLANK);

    ssd_seg_decode u_seg_decode (
        .seg   (w_seg),
        .digit (w_digit),
        .valid (w_code_ok)
    );

    // Frame FSM
    ssd_state_t r_state;
    ssd_state_t w_state_next;
    logic [3:0] w_exp_anode;
    logic       w_good;
    logic       w_load3;
    logic       w_load2;
    logic       w_load1;
    logic       w_load0;
    logic       w_complete;
    logic       w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_exp_anode  = c_AN_POS3;
        w_good       = 1'b0;
        w_load3      = 1'b0;
        w_load2      = 1'b0;
        w_load1      = 1'b0;
        w_load0      = 1'b0;
        w_complete   = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            ST_EXP2: w_exp_anode = c_AN_POS2;
            ST_EXP1: w_exp_anode = c_AN_POS1;
            ST_EXP0: w_exp_anode = c_AN_POS0;
            default: w_exp_anode = c_AN_POS3;
        endcase

        // Multi-hot anodes never equal a position code, so they fail here too
        w_good = (w_anode == w_exp_anode) && w_code_ok;

        if (w_accept && !w_blank) begin
            if (r_state == ST_HUNT) begin
                if (w_good) begin
                    w_load3      = 1'b1;
                    w_state_next = ST_EXP2;
                end
            end else if (!w_good) begin
                w_err        = 1'b1;
                w_state_next = ST_HUNT;
            end else begin
                case (r_state)
                    ST_EXP2: begin
                        w_load2      = 1'b1;
                        w_state_next = ST_EXP1;
                    end
                    ST_EXP1: begin
                        w_load1      = 1'b1;
                        w_state_next = ST_EXP0;
                    end
                    ST_EXP0: begin
                        w_load0      = 1'b1;
                        w_complete   = 1'b1;
                        w_state_next = ST_EXP3;
                    end
                    default: begin
                        w_load3      = 1'b1;
                        w_state_next = ST_EXP2;
                    end
                endcase
            end
        end
    end

    // Digit capture and output registers
    logic [3:0]  r_d3;
    logic [3:0]  r_d2;
    logic [3:0]  r_d1;
    logic [3:0]  r_d0;
    logic        r_complete;
    logic [15:0] r_value;
    logic [15:0] r_bcd;
    logic        r_valid;
    logic        r_error;
    logic        r_locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d3       <= 4'd0;
            r_d2       <= 4'd0;
            r_d1       <= 4'd0;
            r_d0       <= 4'd0;
            r_complete <= 1'b0;
            r_value    <= 16'd0;
            r_bcd      <= 16'd0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            if (w_load3) r_d3 <= w_digit;
            if (w_load2) r_d2 <= w_digit;
            if (w_load1) r_d1 <= w_digit;
            if (w_load0) r_d0 <= w_digit;

            r_complete <= w_complete;
            r_error    <= w_err;
            r_valid    <= r_complete;

            if (r_complete) begin
                r_value <= bcd_to_bin(r_d3, r_d2, r_d1, r_d0);
                r_bcd   <= {r_d3, r_d2, r_d1, r_d0};
            end

            if (w_err) begin
                r_locked <= 1'b0;
            end else if (r_complete) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign value       = r_value;
    assign digits_bcd  = r_bcd;
    assign value_valid = r_valid;
    assign frame_error = r_error;
    assign locked      = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_decoder
// Description : Directed self-checking bench for ssd_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_decoder;

    localparam logic [3:0] c_P3 = 4'b0111;
    localparam logic [3:0] c_P2 = 4'b1011;
    localparam logic [3:0] c_P1 = 4'b1101;
    localparam logic [3:0] c_P0 = 4'b1110;
    localparam logic [3:0] c_BL = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  anode_in = 4'hF;
    logic [6:0]  seg_in = 7'h7F;
    logic [15:0] value;
    logic [15:0] digits_bcd;
    logic        value_valid;
    logic        frame_error;
    logic        locked;

    logic [6:0] seg_tbl [10];
    logic [3:0] pos_tbl [4];

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    ssd_scan_decoder #(
        .DWELL_MIN   (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .anode_in    (anode_in),
        .seg_in      (seg_in),
        .value       (value),
        .digits_bcd  (digits_bcd),
        .value_valid (value_valid),
        .frame_error (frame_error),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (value_valid) valid_cnt += 1;
            if (frame_error) err_cnt += 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp += 1;
        assert (obs === exp) else begin
            n_err += 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        anode_in = a;
        seg_in   = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic show(input int pos, input int d);
        hold(pos_tbl[pos], seg_tbl[d], 8);
        hold(c_BL, 7'h7F, 3);
    endtask

    task automatic frame(input int d3, input int d2, input int d1, input int d0);
        show(3, d3);
        show(2, d2);
        show(1, d1);
        show(0, d0);
    endtask

    initial begin
        seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        pos_tbl = '{c_P0, c_P1, c_P2, c_P3};

        hold(c_BL, 7'h7F, 3);
        rst = 1'b0;
        check("reset_value", 32'(value), 32'h0);
        check("reset_bcd", 32'(digits_bcd), 32'h0);
        check("reset_valid", 32'(value_valid), 32'h0);
        check("reset_error", 32'(frame_error), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);

        // First 1234 frame with exact valid-pulse timing on the position-0 digit
        show(3, 1);
        show(2, 2);
        show(1, 3);
        hold(c_P0, seg_tbl[4], 6);
        check("valid_early", 32'(value_valid), 32'h0);
        hold(c_P0, seg_tbl[4], 1);
        check("valid_pulse", 32'(value_valid), 32'h1);
        check("value_at_pulse", 32'(value), 32'h04D2);
        hold(c_P0, seg_tbl[4], 1);
        check("valid_one_cycle", 32'(value_valid), 32'h0);
        hold(c_BL, 7'h7F, 3);
        check("f1_value", 32'(value), 32'h04D2);
        check("f1_bcd", 32'(digits_bcd), 32'h1234);
        check("f1_locked", 32'(locked), 32'h1);
        check("f1_valid_cnt", 32'(valid_cnt), 32'd1);
        frame(1, 2, 3, 4);
        check("f2_valid_cnt", 32'(valid_cnt), 32'd2);
        check("f2_err_cnt", 32'(err_cnt), 32'd0);
        check("f2_value", 32'(value), 32'h04D2);

        // 9999 started at position 1 from HUNT
        rst = 1'b1;
        hold(c_BL, 7'h7F, 2);
        rst = 1'b0;
        show(1, 9);
        show(0, 9);
        check("mid_start_err", 32'(err_cnt), 32'd0);
        check("mid_start_valid", 32'(valid_cnt), 32'd2);
        frame(9, 9, 9, 9);
        check("f9999_value", 32'(value), 32'h270F);
        check("f9999_bcd", 32'(digits_bcd), 32'h9999);
        check("f9999_valid_cnt", 32'(valid_cnt), 32'd3);
        check("f9999_locked", 32'(locked), 32'h1);

        // Invalid segment code on digit 2 in a locked stream
        frame(1, 2, 3, 4);
        check("relock_value", 32'(value), 32'h04D2);
        show(3, 1);
        hold(c_P2, 7'b1111111, 8);
        hold(c_BL, 7'h7F, 3);
        show(1, 3);
        show(0, 4);
        check("badcode_err_cnt", 32'(err_cnt), 32'd1);
        check("badcode_locked", 32'(locked), 32'h0);
        check("badcode_value", 32'(value), 32'h04D2);
        check("badcode_valid_cnt", 32'(valid_cnt), 32'd4);
        frame(8, 7, 6, 5);
        check("f8765_value", 32'(value), 32'h223D);
        check("f8765_locked", 32'(locked), 32'h1);
        check("f8765_valid_cnt", 32'(valid_cnt), 32'd5);

        // Short glitch inside the position-1 window
        show(3, 8);
        show(2, 7);
        hold(c_P1, seg_tbl[6], 3);
        hold(c_P1, 7'b0000000, 2);
        hold(c_P1, seg_tbl[6], 5);
        hold(c_BL, 7'h7F, 3);
        show(0, 5);
        check("glitch_err_cnt", 32'(err_cnt), 32'd1);
        check("glitch_value", 32'(value), 32'h223D);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd6);
        check("glitch_locked", 32'(locked), 32'h1);

        // Position 2 skipped: exact frame_error timing
        show(3, 1);
        hold(c_P1, seg_tbl[2], 5);
        check("skip_err_early", 32'(frame_error), 32'h0);
        hold(c_P1, seg_tbl[2], 1);
        check("skip_err_pulse", 32'(frame_error), 32'h1);
        hold(c_P1, seg_tbl[2], 1);
        check("skip_err_one_cycle", 32'(frame_error), 32'h0);
        hold(c_P1, seg_tbl[2], 1);
        hold(c_BL, 7'h7F, 3);
        check("skip_locked", 32'(locked), 32'h0);
        check("skip_err_cnt", 32'(err_cnt), 32'd2);
        show(2, 3);
        show(1, 2);
        show(0, 1);
        check("hunt_ignore_err", 32'(err_cnt), 32'd2);
        check("hunt_ignore_valid", 32'(valid_cnt), 32'd6);
        frame(4, 3, 2, 1);
        check("f4321_value", 32'(value), 32'h10E1);
        check("f4321_locked", 32'(locked), 32'h1);
        check("f4321_valid_cnt", 32'(valid_cnt), 32'd7);

        // Reset in the middle of a 5678 frame
        show(3, 5);
        show(2, 6);
        rst = 1'b1;
        hold(c_BL, 7'h7F, 1);
        rst = 1'b0;
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_bcd", 32'(digits_bcd), 32'h0);
        check("midrst_locked", 32'(locked), 32'h0);
        check("midrst_valid", 32'(value_valid), 32'h0);
        show(1, 7);
        show(0, 8);
        check("midrst_no_valid", 32'(valid_cnt), 32'd7);
        frame(5, 6, 7, 8);
        check("f5678_value", 32'(value), 32'h162E);
        check("f5678_bcd", 32'(digits_bcd), 32'h5678);
        check("f5678_valid_cnt", 32'(valid_cnt), 32'd8);
        check("f5678_err_cnt", 32'(err_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_decoder.md
# ssd_scan_decoder

Monitors the multiplexed four-digit seven-segment bus (active-low one-hot anode plus active-low segment pattern) and reconstructs the decimal number being displayed. It is the receive end of the display scan interface, used for display loopback checking and for reading a scanned display from another board. It produces a binary value and a BCD image with a one-cycle valid pulse per complete, in-order scan frame.

## Interface
- DWELL_MIN, 16: consecutive cycles a synchronized {anode, segment} sample must stay unchanged before it is accepted (≥2).
- SYNC_STAGES, 2: flop stages on the asynchronous input buses (≥2).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- anode_in  in  4  active-low digit select; 0111 is the leftmost digit (position 3), 1110 is the rightmost (position 0).
- seg_in  in  7  active-low segments, bit6..bit0 = a..g.
- value  out  16  decoded number, 0..9999, zero-extended.
- digits_bcd  out  16  BCD digits {d3,d2,d1,d0}.
- value_valid  out  1  one-cycle pulse when value/digits_bcd are updated.
- frame_error  out  1  one-cycle pulse on a protocol violation.
- locked  out  1  high after the first good frame; cleared on error or reset.

## Operation
- Synchronizer: both buses pass through SYNC_STAGES flops. The flops reset to all-ones (blank).
- Dwell filter: a counter clears whenever the synchronized sample differs from the previous cycle, and saturates at DWELL_MIN-1.
  - An accept strobe fires in exactly the one cycle the counter reaches DWELL_MIN-1.
  - A stable sample is accepted once. Shorter glitches are dropped.
- Classification of an accepted sample:
  - anode 1111 (blank): ignored in every state.
  - Multi-hot anode: treated as a violation.
- Segment codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other code is invalid.
- FSM states: HUNT, EXP2, EXP1, EXP0, EXP3.
  - HUNT: an accept at position 3 with a valid code stores d3 and moves to EXP2. All other accepts are ignored silently, with no error.
  - EXP2/EXP1/EXP0: an accept at the expected position with a valid code stores the digit and advances. From EXP0 the FSM goes to EXP3 and the frame completes.
  - EXP3: a position-3 accept with a valid code stores d3 and moves to EXP2.
  - Violations:
    - Trigger: in any state other than HUNT, a wrong position (including a repeat of the same position), an invalid code, or a multi-hot anode.
    - Effect: frame_error pulses, the partial frame is discarded, locked clears, and the FSM goes to HUNT.
- Frame completion:
  - value = d3·1000 + d2·100 + d1·10 + d0, computed with shift-add and registered.
  - digits_bcd is updated and value_valid pulses.
  - locked sets.
- value and digits_bcd hold between frames. They are not cleared by frame_error.

## Timing
- Reset values:
  - value, digits_bcd, value_valid, frame_error, locked: 0.
  - FSM: HUNT. Dwell counter: 0. Sync flops: all-ones.
- A pin change becomes visible at the synchronizer output SYNC_STAGES edges later.
- Accept occurs DWELL_MIN-1 cycles after the synchronized change, i.e. in the DWELL_MIN-th cycle of stability.
- Digit register and FSM update at the end of the accept cycle A.
- value, digits_bcd and value_valid update at the end of cycle A+1 for the position-0 accept, so value_valid is high in cycle A+2.
- frame_error is high in cycle A+1 for the offending accept.
- Reset asserted mid-frame discards captured digits. The first valid output after release requires a full new frame starting at position 3.

## Structure
- Package ssd_pkg holds:
  - the ten segment-code constants;
  - the anode position constants (0111, 1011, 1101, 1110, 1111);
  - the FSM state enum.
- Sub-module ssd_seg_decode: purely combinational, 7-bit pattern → 4-bit digit plus valid flag. It is shared with future display logic.

## Test plan
All scenarios use DWELL_MIN=4 and SYNC_STAGES=2.
- Repeated scan of 1234, each digit held 8 cycles, with 1111 blanks of 3 cycles between digits → first frame gives value=1234 (0x04D2), digits_bcd=0x1234, locked=1; value_valid pulses exactly once per frame.
- Scan of 9999 started at position 1 → positions 1 and 0 ignored with no frame_error; first value_valid comes after the next full 3-2-1-0 frame, value=9999 (0x270F).
- Digit 2 shows 1111111 (invalid code) for 8 cycles in a locked stream → one frame_error pulse, locked=0, value keeps its previous value; the next clean frame restores locked=1.
- A 2-cycle glitch of 0000000 inside a stable digit-1 window → no error, no extra accept, value unchanged.
- Anode sequence 0111 → 1101 (position 2 skipped), each held 8 cycles → frame_error pulse, FSM returns to HUNT.
- rst pulsed for 1 cycle after d3 and d2 of 5678 are captured → all outputs 0 the next cycle; a following full 5678 frame yields value=5678 (0x162E).
